// File: rtl/mem_stage_sram_ctrl_pkg.sv
// Shared types and constants for the MEM-stage SRAM controller.
// Holds the FSM state enum, SRAM widths, default base address and word mapping.
package mem_stage_sram_ctrl_pkg;

    localparam int SRAM_AW = 18;
    localparam int SRAM_DW = 16;
    localparam int TAG_W   = 17;

    localparam logic [31:0] DEF_BASE_ADDR = 32'd1024;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOW,
        S_HIGH,
        S_DONE
    } state_e;

    // 32-bit word index relative to the SRAM window; addr[1:0] drop out.
    function automatic logic [TAG_W-1:0] word_of(
        input logic [31:0] a,
        input logic [31:0] base
    );
        return TAG_W'((a - base) >> 2);
    endfunction

endpackage

// File: rtl/mem_read_buffer.sv
// One-entry read buffer (valid, word tag, 32-bit data) for the SRAM controller.
// Ports: look_tag_i/hit_o/data_o lookup; fill_i loads; upd_i refreshes on tag match.
module mem_read_buffer
    import mem_stage_sram_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [TAG_W-1:0] look_tag_i,
    output logic             hit_o,
    output logic [31:0]      data_o,
    input  logic             fill_i,
    input  logic             upd_i,
    input  logic [TAG_W-1:0] tag_i,
    input  logic [31:0]      data_i
);

    logic             valid_q, valid_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic [31:0]      data_q, data_d;

    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        data_d  = data_q;
        if (fill_i) begin
            valid_d = 1'b1;
            tag_d   = tag_i;
            data_d  = data_i;
        end else if (upd_i && valid_q && (tag_q == tag_i)) begin
            data_d  = data_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            tag_q   <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            tag_q   <= tag_d;
            data_q  <= data_d;
        end
    end

    assign hit_o  = valid_q && (tag_q == look_tag_i);
    assign data_o = data_q;

endmodule

// File: rtl/mem_stage_sram_ctrl.sv
// MEM-stage controller: splits 32-bit loads/stores into two 16-bit SRAM accesses.
// Ports: clk, rst (async high); mem_r_en/mem_w_en/addr/wdata in; rdata/ready out;
// sram_addr/sram_dq_out/sram_dq_in/sram_dq_oe/sram_we_n to the SRAM.
// Optional read buffer: define MEM_READ_BUFFER_EN.
module mem_stage_sram_ctrl
    import mem_stage_sram_ctrl_pkg::*;
#(
    parameter int          WAIT_CYCLES = 2,
    parameter logic [31:0] BASE_ADDR   = DEF_BASE_ADDR
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               mem_r_en,
    input  logic               mem_w_en,
    input  logic [31:0]        addr,
    input  logic [31:0]        wdata,
    output logic [31:0]        rdata,
    output logic               ready,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [SRAM_DW-1:0] sram_dq_out,
    input  logic [SRAM_DW-1:0] sram_dq_in,
    output logic               sram_dq_oe,
    output logic               sram_we_n
);

    localparam logic [3:0] CNT_LAST = 4'(WAIT_CYCLES - 1);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        we_q, we_d;
    logic [31:0] rdata_q, rdata_d;

    logic             req;
    logic             rd_req;
    logic             last;
    logic             active;
    logic             hsel;
    logic             wr_act;
    logic [TAG_W-1:0] word_q;
    logic             buf_hit;
    logic [31:0]      buf_data;

    // Both enables set means store.
    assign req    = mem_r_en | mem_w_en;
    assign rd_req = mem_r_en & ~mem_w_en;
    assign last   = (cnt_q == CNT_LAST);
    assign word_q = word_of(addr_q, BASE_ADDR);

`ifdef MEM_READ_BUFFER_EN
    logic look_hit;

    mem_read_buffer u_rbuf (
        .clk        (clk),
        .rst        (rst),
        .look_tag_i (word_of(addr, BASE_ADDR)),
        .hit_o      (look_hit),
        .data_o     (buf_data),
        .fill_i     ((state_q == S_DONE) && !we_q),
        .upd_i      ((state_q == S_DONE) && we_q),
        .tag_i      (word_q),
        .data_i     (we_q ? wdata_q : rdata_q)
    );

    // Hits are only served from IDLE so an access is never interrupted.
    assign buf_hit = (state_q == S_IDLE) && rd_req && look_hit;
`else
    assign buf_hit  = 1'b0;
    assign buf_data = '0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        we_d    = we_q;
        rdata_d = rdata_q;
        unique case (state_q)
            S_IDLE: begin
                if (buf_hit) begin
                    rdata_d = buf_data;
                end else if (req) begin
                    state_d = S_LOW;
                    cnt_d   = '0;
                    addr_d  = addr;
                    wdata_d = wdata;
                    we_d    = mem_w_en;
                end
            end
            S_LOW: begin
                if (last) begin
                    state_d = S_HIGH;
                    cnt_d   = '0;
                    if (!we_q) rdata_d[15:0] = sram_dq_in;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_HIGH: begin
                if (last) begin
                    state_d = S_DONE;
                    cnt_d   = '0;
                    if (!we_q) rdata_d[31:16] = sram_dq_in;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            rdata_q <= rdata_d;
        end
    end

    assign active = (state_q == S_LOW) || (state_q == S_HIGH);
    assign hsel   = (state_q == S_HIGH);
    assign wr_act = active && we_q;

    assign sram_addr   = active ? {word_q, hsel} : '0;
    assign sram_dq_oe  = wr_act;
    assign sram_we_n   = ~wr_act;
    assign sram_dq_out = !wr_act ? '0
                       : hsel    ? wdata_q[31:16]
                       :           wdata_q[15:0];

    // No request means nothing to stall; a hit completes in IDLE.
    assign ready = ~req | (state_q == S_DONE) | buf_hit;
    assign rdata = buf_hit ? buf_data : rdata_q;

endmodule

// File: tb/tb_mem_stage_sram_ctrl.sv
// Scoreboard bench for mem_stage_sram_ctrl with a small SRAM model.
// Honours MEM_READ_BUFFER_EN for the buffered-read expectations.
module tb_mem_stage_sram_ctrl;

    localparam int W = 2;
`ifdef MEM_READ_BUFFER_EN
    localparam int HIT_STALL = 0;
`else
    localparam int HIT_STALL = 5;
`endif

    typedef struct {
        int          stall;
        bit          chk;
        logic [31:0] rd;
        int          gap;
    } exp_t;

    typedef struct {
        logic [17:0] a;
        logic [15:0] d;
    } beat_t;

    logic        clk;
    logic        rst;
    logic        mem_r_en;
    logic        mem_w_en;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ready;
    logic [17:0] sram_addr;
    logic [15:0] sram_dq_out;
    logic [15:0] sram_dq_in;
    logic        sram_dq_oe;
    logic        sram_we_n;

    mem_stage_sram_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .mem_r_en    (mem_r_en),
        .mem_w_en    (mem_w_en),
        .addr        (addr),
        .wdata       (wdata),
        .rdata       (rdata),
        .ready       (ready),
        .sram_addr   (sram_addr),
        .sram_dq_out (sram_dq_out),
        .sram_dq_in  (sram_dq_in),
        .sram_dq_oe  (sram_dq_oe),
        .sram_we_n   (sram_we_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [15:0] smem [0:15] = '{2: 16'h5678, 3: 16'h1234, default: 16'h0};
    assign sram_dq_in = smem[sram_addr[3:0]];
    always @(negedge clk) begin
        if (!sram_we_n) smem[sram_addr[3:0]] <= sram_dq_out;
    end

    exp_t  sb [0:63];
    beat_t bt [0:63];
    int    sb_wr, sb_rd;
    int    bt_wr, bt_rd;
    int    n_iss, done_n, tmo;
    bit    fin;
    int    n_cmp, n_fail;
    int    stall, cyc, last_cyc;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    initial begin
        sb_rd = 0; bt_rd = 0; done_n = 0;
        n_cmp = 0; n_fail = 0; stall = 0; cyc = 0; last_cyc = 0;
    end

    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (fin) begin
            chk("beats_left", 32'(bt_wr - bt_rd), 32'd0);
            chk("sb_left", 32'(sb_wr - sb_rd), 32'd0);
            chk("timeouts", 32'(tmo), 32'd0);
            $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                     n_cmp, n_fail);
            $finish;
        end else if (rst) begin
            stall = 0;
            chk("rst_we_n", 32'(sram_we_n), 32'd1);
            chk("rst_oe", 32'(sram_dq_oe), 32'd0);
            chk("rst_ready", 32'(ready), 32'd1);
            chk("rst_addr", 32'(sram_addr), 32'd0);
            chk("rst_dq", 32'(sram_dq_out), 32'd0);
            chk("rst_rdata", rdata, 32'd0);
        end else begin
            if (!sram_we_n) begin
                if (bt_rd == bt_wr) begin
                    n_cmp++; n_fail++;
                    $display("FAIL beat_extra: got addr %0h want none",
                             sram_addr);
                end else begin
                    chk("beat_addr", 32'(sram_addr), 32'(bt[bt_rd].a));
                    chk("beat_dq", 32'(sram_dq_out), 32'(bt[bt_rd].d));
                    chk("beat_oe", 32'(sram_dq_oe), 32'd1);
                    bt_rd++;
                end
            end
            if ((mem_r_en || mem_w_en) && !ready) begin
                stall++;
            end else if (mem_r_en || mem_w_en) begin
                if (sb_rd == sb_wr) begin
                    n_cmp++; n_fail++;
                    $display("FAIL sb_extra: got completion want none");
                end else begin
                    e = sb[sb_rd];
                    sb_rd++;
                    chk("stall", 32'(stall), 32'(e.stall));
                    if (e.chk) chk("rdata", rdata, e.rd);
                    if (e.gap >= 0)
                        chk("gap", 32'(cyc - last_cyc), 32'(e.gap));
                    if (e.stall == 0) begin
                        chk("hit_addr", 32'(sram_addr), 32'd0);
                        chk("hit_oe", 32'(sram_dq_oe), 32'd0);
                    end
                end
                last_cyc = cyc;
                stall    = 0;
                done_n++;
            end else begin
                stall = 0;
            end
        end
    end

    task automatic beats(input logic [17:0] a, input logic [15:0] d);
        for (int i = 0; i < W; i++) begin
            bt[bt_wr] = '{a: a, d: d};
            bt_wr++;
        end
    endtask

    task automatic wait_done();
        bit ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            #1;
            if (done_n >= n_iss) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) tmo++;
    endtask

    task automatic txn(input bit r, input bit w, input logic [31:0] a,
                       input logic [31:0] d, input int st, input bit c,
                       input logic [31:0] rd, input int gap);
        sb[sb_wr] = '{stall: st, chk: c, rd: rd, gap: gap};
        sb_wr++;
        n_iss++;
        @(posedge clk);
        #1;
        mem_r_en = r;
        mem_w_en = w;
        addr     = a;
        wdata    = d;
        wait_done();
    endtask

    task automatic idle(input int n);
        @(posedge clk);
        #1;
        mem_r_en = 1'b0;
        mem_w_en = 1'b0;
        repeat (n - 1) @(posedge clk);
    endtask

    initial begin
        rst = 1'b1; mem_r_en = 1'b0; mem_w_en = 1'b0;
        addr = '0; wdata = '0;
        fin = 1'b0; tmo = 0; sb_wr = 0; bt_wr = 0; n_iss = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        beats(18'd0, 16'hBEEF); beats(18'd1, 16'hDEAD);
        txn(0, 1, 32'd1024, 32'hDEADBEEF, 5, 0, 0, -1);
        idle(1);
        txn(1, 0, 32'd1028, 32'h0, 5, 1, 32'h12345678, -1);
        idle(1);
        txn(1, 0, 32'd1026, 32'h0, 5, 1, 32'hDEADBEEF, -1);
        idle(1);

        beats(18'd4, 16'hF00D); beats(18'd5, 16'hCAFE);
        txn(1, 1, 32'd1032, 32'hCAFEF00D, 5, 1, 32'hDEADBEEF, -1);
        idle(1);

        beats(18'd6, 16'h2222); beats(18'd7, 16'h1111);
        beats(18'd8, 16'h4444); beats(18'd9, 16'h3333);
        txn(0, 1, 32'd1036, 32'h11112222, 5, 0, 0, -1);
        txn(0, 1, 32'd1040, 32'h33334444, 5, 0, 0, 6);
        idle(1);

        // Inputs change, then request withdrawn; access must still finish.
        beats(18'd10, 16'h5A5A); beats(18'd11, 16'hA5A5);
        @(posedge clk);
        #1 mem_w_en = 1'b1; addr = 32'd1044; wdata = 32'hA5A55A5A;
        @(posedge clk);
        #1 addr = 32'd1100; wdata = 32'h0;
        @(posedge clk);
        #1 mem_w_en = 1'b0;
        repeat (8) @(posedge clk);

        // Reset in the second HIGH cycle of a write.
        bt[bt_wr] = '{a: 18'd0, d: 16'hF00D}; bt_wr++;
        bt[bt_wr] = '{a: 18'd0, d: 16'hF00D}; bt_wr++;
        bt[bt_wr] = '{a: 18'd1, d: 16'h0BAD}; bt_wr++;
        @(posedge clk);
        #1 mem_w_en = 1'b1; addr = 32'd1024; wdata = 32'h0BADF00D;
        repeat (4) @(posedge clk);
        #1 rst = 1'b1; mem_w_en = 1'b0;
        @(negedge clk);
        @(posedge clk);
        #1 rst = 1'b0;

        txn(1, 0, 32'd1028, 32'h0, 5, 1, 32'h12345678, -1);
        idle(1);
        txn(1, 0, 32'd1028, 32'h0, HIT_STALL, 1, 32'h12345678, -1);
        idle(1);
        beats(18'd2, 16'h0000); beats(18'd3, 16'h0000);
        txn(0, 1, 32'd1028, 32'h0, 5, 0, 0, -1);
        idle(1);
        txn(1, 0, 32'd1028, 32'h0, HIT_STALL, 1, 32'h0, -1);
        idle(2);
        fin = 1'b1;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog");
    end

endmodule
